// File: rtl/pipeline_controller_pkg.sv
// rtl/pipeline_controller_pkg.sv - shared types and sizing helpers for the pipeline controller
package pipeline_ctrl_pkg;

   typedef enum logic [2:0] {
      RUN,
      FLUSH,
      DRAIN,
      HALT_FLUSH,
      HALTED
   } pipe_ctrl_state_e;

   // Counter must hold either the drain budget or the flush length.
   function automatic int PIPE_CTRL_CNT_W(input int num_stages, input int flush_cycles);
      int m;
      m = (num_stages > flush_cycles) ? num_stages : flush_cycles;
      return $clog2(m + 1);
   endfunction

   function automatic int pipe_ctrl_sel_w(input int num_stages);
      return (num_stages > 1) ? $clog2(num_stages) : 1;
   endfunction

endpackage

// File: rtl/pipeline_controller_if.sv
// rtl/pipeline_controller_if.sv - request, stage control and stage status signals of the controller
interface pipeline_controller_if #(
   parameter int NUM_STAGES = 4
);
   import pipeline_ctrl_pkg::*;

   localparam int SEL_W = pipe_ctrl_sel_w(NUM_STAGES);

   logic [NUM_STAGES-1:0] stall_req;
   logic                  flush_req;
   logic [SEL_W-1:0]      flush_stage;
   logic                  halt_req;
   logic                  resume;
   logic [NUM_STAGES-1:0] s_status_busy;
   logic [NUM_STAGES-1:0] m_ctrl_stall;
   logic [NUM_STAGES-1:0] m_ctrl_flush;
   logic                  flush_ack;
   logic                  halted;
   logic                  pipe_empty;

   modport master (
      input  stall_req, flush_req, flush_stage, halt_req, resume, s_status_busy,
      output m_ctrl_stall, m_ctrl_flush, flush_ack, halted, pipe_empty
   );

   modport slave (
      output stall_req, flush_req, flush_stage, halt_req, resume, s_status_busy,
      input  m_ctrl_stall, m_ctrl_flush, flush_ack, halted, pipe_empty
   );

endinterface

// File: rtl/pipeline_controller_stall_propagator.sv
// rtl/pipeline_controller_stall_propagator.sv - suffix-OR stall fan-out toward upstream stages
module stall_propagator #(
   parameter int NUM_STAGES = 4
) (
   input  logic [NUM_STAGES-1:0] stall_req_i,
   input  logic                  force_first_i,
   input  logic                  force_all_i,
   output logic [NUM_STAGES-1:0] stall_o
);

   logic acc;

   // A stall at stage i must also hold every older stage feeding it.
   always_comb begin
      stall_o = '0;
      acc     = 1'b0;
      for (int j = NUM_STAGES - 1; j >= 0; j--) begin
         acc        = acc | stall_req_i[j];
         stall_o[j] = acc;
      end
      if (force_first_i) begin
         stall_o[0] = 1'b1;
      end
      if (force_all_i) begin
         stall_o = '1;
      end
   end

endmodule

// File: rtl/pipeline_controller.sv
// rtl/pipeline_controller.sv - stall propagation, partial flush sequencing and drain-and-halt control
module pipeline_controller
   import pipeline_ctrl_pkg::*;
#(
   parameter int NUM_STAGES   = 4,
   parameter int FLUSH_CYCLES = 1
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   pipeline_controller_if.master  pif
);

   localparam int CNT_W = PIPE_CTRL_CNT_W(NUM_STAGES, FLUSH_CYCLES);
   localparam int SEL_W = pipe_ctrl_sel_w(NUM_STAGES);

   pipe_ctrl_state_e      state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [SEL_W-1:0]      stage_q, stage_d;
   logic [NUM_STAGES-1:0] flush_vec;
   logic                  upper_stall;

   assign pif.pipe_empty = ~|pif.s_status_busy;
   assign upper_stall    = (pif.stall_req >> 1) != '0;

   stall_propagator #(
      .NUM_STAGES (NUM_STAGES)
   ) u_stall_propagator (
      .stall_req_i   (pif.stall_req),
      .force_first_i (state_q == DRAIN),
      .force_all_i   ((state_q == HALT_FLUSH) || (state_q == HALTED)),
      .stall_o       (pif.m_ctrl_stall)
   );

   // Flush, ack and halted come only from registered state so they never glitch on inputs.
   always_comb begin
      flush_vec = '0;
      for (int j = 0; j < NUM_STAGES; j++) begin
         flush_vec[j] = ((state_q == FLUSH) && (j <= int'(stage_q))) || (state_q == HALT_FLUSH);
      end
   end

   assign pif.m_ctrl_flush = flush_vec;
   assign pif.flush_ack    = (state_q == FLUSH) && (cnt_q == CNT_W'(1));
   assign pif.halted       = (state_q == HALTED);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      stage_d = stage_q;
      unique case (state_q)
         RUN: begin
            if (pif.flush_req) begin
               if (int'(pif.flush_stage) >= NUM_STAGES) begin
                  stage_d = SEL_W'(NUM_STAGES - 1);
               end else begin
                  stage_d = pif.flush_stage;
               end
               cnt_d   = CNT_W'(FLUSH_CYCLES);
               state_d = FLUSH;
            end else if (pif.halt_req) begin
               cnt_d   = CNT_W'(NUM_STAGES);
               state_d = DRAIN;
            end
         end
         FLUSH: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end
            if (cnt_q <= CNT_W'(1)) begin
               state_d = RUN;
            end
         end
         DRAIN: begin
            // Downstream stalls freeze the drain budget; a stage-0 stall alone does not.
            if (pif.pipe_empty) begin
               cnt_d   = '0;
               state_d = HALT_FLUSH;
            end else if (!upper_stall && (cnt_q != '0)) begin
               cnt_d = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  state_d = HALT_FLUSH;
               end
            end
         end
         HALT_FLUSH: begin
            state_d = HALTED;
         end
         HALTED: begin
            if (pif.resume) begin
               state_d = RUN;
            end
         end
         default: begin
            state_d = RUN;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= RUN;
         cnt_q   <= '0;
         stage_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         stage_q <= stage_d;
      end
   end

endmodule

// File: tb/tb_pipeline_controller.sv
// tb/tb_pipeline_controller.sv - directed and randomized bench for pipeline_controller against a behavioural model
module tb_pipeline_controller;

   localparam int NS = 4;
   localparam int FC = 2;

   logic clk;
   logic rst;

   pipeline_controller_if #(.NUM_STAGES(NS)) dif ();

   pipeline_controller #(
      .NUM_STAGES   (NS),
      .FLUSH_CYCLES (FC)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .pif   (dif.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks;
   int n_fail;

   // Model: remaining flush cycles, flush depth, remaining drain budget and phase flags.
   int m_flush_left;
   int m_depth;
   int m_drain_left;
   bit m_draining;
   bit m_hflush;
   bit m_halted;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [NS-1:0] exp_stall();
      logic [NS-1:0] s;
      for (int j = 0; j < NS; j++) s[j] = (dif.stall_req >> j) != 0;
      if (m_draining) s[0] = 1'b1;
      if (m_hflush || m_halted) s = '1;
      return s;
   endfunction

   function automatic logic [NS-1:0] exp_flush();
      logic [NS-1:0] f;
      f = '0;
      if (m_flush_left > 0)
         for (int j = 0; j < NS; j++) if (j <= m_depth) f[j] = 1'b1;
      if (m_hflush) f = '1;
      return f;
   endfunction

   task automatic model_edge();
      if (rst) begin
         m_flush_left = 0; m_draining = 0; m_hflush = 0; m_halted = 0; m_drain_left = 0;
      end else if (m_flush_left > 0) begin
         m_flush_left--;
      end else if (m_hflush) begin
         m_hflush = 0; m_halted = 1;
      end else if (m_halted) begin
         if (dif.resume) m_halted = 0;
      end else if (m_draining) begin
         if (dif.s_status_busy == 0) begin
            m_draining = 0; m_hflush = 1;
         end else if ((dif.stall_req >> 1) == 0) begin
            if (m_drain_left == 1) begin
               m_draining = 0; m_hflush = 1;
            end else begin
               m_drain_left--;
            end
         end
      end else if (dif.flush_req) begin
         m_flush_left = FC;
         m_depth = (int'(dif.flush_stage) > NS - 1) ? NS - 1 : int'(dif.flush_stage);
      end else if (dif.halt_req) begin
         m_draining = 1; m_drain_left = NS;
      end
   endtask

   task automatic compare_all();
      chk("stall", dif.m_ctrl_stall, exp_stall());
      chk("flush", dif.m_ctrl_flush, exp_flush());
      chk("flush_ack", dif.flush_ack, (m_flush_left == 1));
      chk("halted", dif.halted, m_halted);
      chk("pipe_empty", dif.pipe_empty, (dif.s_status_busy == 0));
   endtask

   task automatic step();
      @(negedge clk);
      compare_all();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic wait_halted(output int cycles);
      cycles = 0;
      while (!dif.halted && cycles < 30) begin
         step();
         cycles++;
      end
   endtask

   int cyc;

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst = 1'b1;
      dif.stall_req = '0; dif.flush_req = 1'b0; dif.flush_stage = '0;
      dif.halt_req = 1'b0; dif.resume = 1'b0; dif.s_status_busy = '0;
      m_flush_left = 0; m_depth = 0; m_drain_left = 0;
      m_draining = 0; m_hflush = 0; m_halted = 0;
      @(posedge clk);
      model_edge();
      #1;

      // Reset
      step();
      step();
      rst = 1'b0;
      chk("rst_stall", dif.m_ctrl_stall, 4'b0000);
      chk("rst_flush", dif.m_ctrl_flush, 4'b0000);
      chk("rst_halted", dif.halted, 1'b0);
      chk("rst_ack", dif.flush_ack, 1'b0);

      // Stall propagation
      dif.s_status_busy = 4'b1111;
      dif.stall_req = 4'b0100; #1;
      chk("prop_0100", dif.m_ctrl_stall, 4'b0111);
      step();
      dif.stall_req = 4'b0001; #1;
      chk("prop_0001", dif.m_ctrl_stall, 4'b0001);
      step();
      dif.stall_req = 4'b0000;

      // Partial flush
      dif.flush_req = 1'b1; dif.flush_stage = 2'd2;
      step();
      dif.flush_req = 1'b0;
      chk("pf_t1_flush", dif.m_ctrl_flush, 4'b0111);
      chk("pf_t1_ack", dif.flush_ack, 1'b0);
      step();
      chk("pf_t2_flush", dif.m_ctrl_flush, 4'b0111);
      chk("pf_t2_ack", dif.flush_ack, 1'b1);
      step();
      chk("pf_t3_flush", dif.m_ctrl_flush, 4'b0000);
      chk("pf_t3_ack", dif.flush_ack, 1'b0);

      // Simultaneous flush and held halt
      dif.flush_req = 1'b1; dif.halt_req = 1'b1; dif.flush_stage = 2'd1;
      step();
      dif.flush_req = 1'b0;
      chk("sim_flush", dif.m_ctrl_flush, 4'b0011);
      step();
      chk("sim_ack", dif.flush_ack, 1'b1);
      step();
      chk("sim_run_flush", dif.m_ctrl_flush, 4'b0000);
      step();
      dif.halt_req = 1'b0;
      chk("sim_drain_stall", dif.m_ctrl_stall, 4'b0001);
      wait_halted(cyc);
      chk("sim_halt_cycles", cyc, NS + 1);
      dif.resume = 1'b1;
      step();
      dif.resume = 1'b0;
      chk("resume_stall", dif.m_ctrl_stall, 4'b0000);
      chk("resume_halted", dif.halted, 1'b0);

      // Drain and halt, full pipe
      dif.halt_req = 1'b1;
      step();
      dif.halt_req = 1'b0;
      wait_halted(cyc);
      chk("drain_cycles", cyc, NS + 1);
      dif.resume = 1'b1; step(); dif.resume = 1'b0;

      // Drain with empty pipe
      dif.s_status_busy = 4'b0000;
      dif.halt_req = 1'b1;
      step();
      dif.halt_req = 1'b0;
      wait_halted(cyc);
      chk("empty_drain_cycles", cyc, 2);
      dif.resume = 1'b1; step(); dif.resume = 1'b0;

      // Drain extended by downstream stall
      dif.s_status_busy = 4'b1111;
      dif.halt_req = 1'b1;
      step();
      dif.halt_req = 1'b0;
      step();
      dif.stall_req = 4'b1000;
      repeat (3) step();
      dif.stall_req = 4'b0000;
      wait_halted(cyc);
      chk("stalled_drain_cycles", cyc + 4, NS + 1 + 3);
      dif.resume = 1'b1; step(); dif.resume = 1'b0;

      // Reset mid-drain
      dif.halt_req = 1'b1;
      step();
      dif.halt_req = 1'b0;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst_drain_halted", dif.halted, 1'b0);
      chk("rst_drain_stall", dif.m_ctrl_stall, 4'b0000);
      repeat (8) step();
      chk("rst_drain_no_halt", dif.halted, 1'b0);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         rst               = ($urandom_range(0, 99) == 0);
         dif.stall_req     = NS'($urandom & $urandom);
         dif.s_status_busy = ($urandom_range(0, 4) == 0) ? '0 : NS'($urandom);
         dif.flush_req     = ($urandom_range(0, 7) == 0);
         dif.flush_stage   = 2'($urandom_range(0, 3));
         dif.halt_req      = ($urandom_range(0, 9) == 0);
         dif.resume        = ($urandom_range(0, 3) == 0);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
